// File: rtl/button_debouncer.sv
// button_debouncer: conditions raw push-button/switch levels for edge_detector.
// Each bit is brought into clk through a two-flop synchroniser. Contact bounce is
// then filtered by a per-bit saturating counter. That counter advances only on a
// shared low-rate sample tick, and any low synchronised sample clears it at once.
// The output level is decoded purely from registered counter state.
module button_debouncer #(
   parameter int WIDTH          = 2,
   parameter int SAMPLE_CNT_MAX = 62500,
   parameter int PULSE_CNT_MAX  = 200
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] glitchy_signal,
   output logic [WIDTH-1:0] debounced_signal
);

   // Sample counter is at least one bit wide so SAMPLE_CNT_MAX==1 still elaborates.
   // In that case the counter sits at 0 and the tick is permanently high.
   localparam int SCW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
   localparam int PCW = $clog2(PULSE_CNT_MAX + 1);

   localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLE_CNT_MAX - 1);
   localparam logic [PCW-1:0] PULSE_FULL  = PCW'(PULSE_CNT_MAX);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [SCW-1:0]   sample_cnt_q;
   logic [SCW-1:0]   sample_cnt_d;
   logic             sample_tick;

   // Two-stage synchroniser; only sync2_q is used downstream.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= glitchy_signal;
         sync2_q <= sync1_q;
      end
   end

   assign sample_tick = (sample_cnt_q == SAMPLE_LAST);

   // Free-running sample counter; wraps after the tick, never restarted by input activity.
   always_comb begin
      sample_cnt_d = sample_cnt_q + 1'b1;
      if (sample_tick) begin
         sample_cnt_d = '0;
      end
   end

   // Sample counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sample_cnt_q <= '0;
      end else begin
         sample_cnt_q <= sample_cnt_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
         logic [PCW-1:0] pulse_cnt_q;
         logic [PCW-1:0] pulse_cnt_d;

         // Low sample clears immediately (even on a tick); otherwise count ticks up to saturation.
         always_comb begin
            pulse_cnt_d = pulse_cnt_q;
            if (!sync2_q[gi]) begin
               pulse_cnt_d = '0;
            end else if (sample_tick && (pulse_cnt_q < PULSE_FULL)) begin
               pulse_cnt_d = pulse_cnt_q + 1'b1;
            end
         end

         // Per-bit counter register.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               pulse_cnt_q <= '0;
            end else begin
               pulse_cnt_q <= pulse_cnt_d;
            end
         end

         assign debounced_signal[gi] = (pulse_cnt_q == PULSE_FULL);
      end
   endgenerate

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Front-end conditioning stage for raw push-button/switch inputs, placed directly upstream of edge_detector in the button_parse path.
- Synchronises each asynchronous button bit into clk, filters contact bounce with a shared low-rate sample tick and per-bit saturating counters, and emits a clean level.
- edge_detector then converts that level into a one-cycle pulse.
- All bits are independent and share only the sample-tick generator.

Parameters:
- WIDTH, 2, number of button bits processed in parallel (>=1).
- SAMPLE_CNT_MAX, 62500, clk cycles between sample ticks (>=1; 1 = tick every cycle); 62500 at 125 MHz = 0.5 ms.
- PULSE_CNT_MAX, 200, consecutive high samples required before the output asserts (>=1).

Ports:
- clk  input  1  system clock (125 MHz nominal); all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low; sampled on rising clk edge.
- glitchy_signal  input  WIDTH  raw asynchronous button levels.
- debounced_signal  output  WIDTH  filtered, clk-synchronous levels; feeds edge_detector signal_in.

Behaviour:
- Reset (rst_n==0 at a clk edge), applied to all state:
  - both synchroniser stages = 0
  - sample counter = 0
  - all per-bit counters = 0
  - debounced_signal = 0 from the following cycle
- Reset mid-operation discards all accumulated count; filtering restarts from zero after rst_n returns high.
- Synchroniser:
  - Two flops per bit: sync1 <= glitchy_signal, sync2 <= sync1.
  - Only sync2 is used downstream; fixed 2-cycle synchronisation latency.
- Sample tick generator:
  - Free-running counter, width $clog2(SAMPLE_CNT_MAX) (min 1).
  - Counts 0..SAMPLE_CNT_MAX-1, then wraps to 0.
  - sample_tick = (counter == SAMPLE_CNT_MAX-1); high exactly one cycle in every SAMPLE_CNT_MAX.
  - For SAMPLE_CNT_MAX==1, sample_tick is constantly 1.
- Per-bit saturating counter, width $clog2(PULSE_CNT_MAX+1). Update priority:
  1. sync2[i]==0: counter <= 0 on every edge, regardless of sample_tick (immediate release).
  2. sync2[i]==1 and sample_tick and counter < PULSE_CNT_MAX: counter <= counter+1.
  3. sync2[i]==1 and counter == PULSE_CNT_MAX: hold (saturate, no wrap).
  4. Otherwise: hold.
- Output:
  - debounced_signal[i] = (counter[i] == PULSE_CNT_MAX).
  - Decoded only from registered state; glitch-free; no combinational path from glitchy_signal.
- Assert latency: counted from the first edge where the raw input is sampled high and held.
  - sync2 is high after edge 2.
  - Output high after the PULSE_CNT_MAX-th subsequent tick.
  - Window: [2 + (PULSE_CNT_MAX-1)*SAMPLE_CNT_MAX + 1, 2 + PULSE_CNT_MAX*SAMPLE_CNT_MAX] edges.
- Release latency: exactly 3 edges after the raw input is sampled low (2 sync + 1 counter clear).
- Bounce inside the window: any low sample on sync2 clears that bit's count; the output asserts only after an uninterrupted run.
- Simultaneous events:
  - Low input on a tick edge: clear wins.
  - Bits rising together assert on the same tick.
  - One bit's activity never affects another's counter.
- The sample counter is not restarted by input activity; only rst_n restarts it.

Test Plan:
All scenarios use WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, rst_n low for 2 cycles, then high.
1. Reset with glitchy_signal=2'b11 held -> debounced_signal==2'b00 every cycle while rst_n low and on the first cycle after release.
2. Raise glitchy_signal[0] and hold; count edges -> debounced_signal[0] rises no earlier than edge 11 and no later than edge 14, then stays 1; bit1 stays 0 throughout.
3. glitchy_signal[0] high for 5 cycles, low 1 cycle, repeated 4 times -> debounced_signal[0] never asserts (counter never reaches 3).
4. Bit0 asserted and stable, then glitchy_signal[0] driven low -> debounced_signal[0]==0 exactly 3 edges later; reassertion needs a full fresh window (>=11 edges).
5. Bit0 mid-count (2 ticks accumulated), pulse rst_n low one cycle with input still high -> output stays 0; assertion occurs 11..14 edges after rst_n release.
6. Chain into edge_detector (WIDTH=2); press bit0 with 3 bounces, then bit1 cleanly -> exactly one 1-cycle edge_detect_pulse per bit, bit0 pulse before bit1 pulse.
